// File: rtl/dual_core_mem_arbiter_pkg.sv
// rtl/dual_core_mem_arbiter_pkg.sv - shared constants and types for the dual-core memory arbiter
package dual_core_mem_arbiter_pkg;

  localparam int DEFAULT_ADDR_W = 8;
  localparam int NUM_CORES      = 2;
  localparam int CORE_IDX_W     = $clog2(NUM_CORES);
  localparam int WAIT_W         = 16;

  typedef logic [CORE_IDX_W-1:0] core_idx_t;
  typedef logic [WAIT_W-1:0]     wait_cnt_t;

  localparam wait_cnt_t WAIT_MAX       = 16'hFFFF;
  // Pointer starts at core 1 so core 0 wins the first contention.
  localparam core_idx_t LAST_GRANT_RST = 1'b1;

  function automatic wait_cnt_t sat_inc(input wait_cnt_t v);
    return (v == WAIT_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/dual_core_mem_arbiter_shared_data_memory.sv
// rtl/dual_core_mem_arbiter_shared_data_memory.sv - word memory, async dual read, sync write and clear
module shared_data_memory #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic [ADDR_W-1:0] raddr0,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [31:0]       rdata0,
  output logic [31:0]       rdata1
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata0 = mem[raddr0];
  assign rdata1 = mem[raddr1];

endmodule

// File: rtl/dual_core_mem_arbiter.sv
// rtl/dual_core_mem_arbiter.sv - round-robin arbiter giving two cores access to one shared data memory
module dual_core_mem_arbiter
  import dual_core_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_request0,
  input  logic        mem_request1,
  input  logic        mem_read0,
  input  logic        mem_read1,
  input  logic        mem_write0,
  input  logic        mem_write1,
  input  logic [31:0] mem_address0,
  input  logic [31:0] mem_address1,
  input  logic [31:0] mem_write_data0,
  input  logic [31:0] mem_write_data1,
  output logic        mem_grant0,
  output logic        mem_grant1,
  output logic [31:0] mem_read_data0,
  output logic [31:0] mem_read_data1,
  output wait_cnt_t   wait_count0,
  output wait_cnt_t   wait_count1,
  output core_idx_t   last_grant
);

  logic              req0;
  logic              req1;
  logic [ADDR_W-1:0] idx0;
  logic [ADDR_W-1:0] idx1;
  logic              we;
  logic [ADDR_W-1:0] widx;
  logic [31:0]       wdata;
  logic [31:0]       mem_q0;
  logic [31:0]       mem_q1;
  logic              unused_addr_bits;

  // Byte offset and bits above the memory depth are dropped, so addresses alias.
  assign idx0 = mem_address0[ADDR_W+1:2];
  assign idx1 = mem_address1[ADDR_W+1:2];
  assign unused_addr_bits = ^{mem_address0[31:ADDR_W+2], mem_address0[1:0],
                              mem_address1[31:ADDR_W+2], mem_address1[1:0]};

  assign req0 = mem_request0 && !rst;
  assign req1 = mem_request1 && !rst;

  always_comb begin
    mem_grant0 = 1'b0;
    mem_grant1 = 1'b0;
    if (req0 && req1) begin
      mem_grant0 = (last_grant != core_idx_t'(0));
      mem_grant1 = (last_grant != core_idx_t'(1));
    end else begin
      mem_grant0 = req0;
      mem_grant1 = req1;
    end
  end

  // Grants are one-hot, so the granted core alone steers the write port.
  assign we    = (mem_write0 && mem_grant0) || (mem_write1 && mem_grant1);
  assign widx  = mem_grant1 ? idx1 : idx0;
  assign wdata = mem_grant1 ? mem_write_data1 : mem_write_data0;

  shared_data_memory #(
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk    (clk),
    .rst    (rst),
    .we     (we),
    .waddr  (widx),
    .wdata  (wdata),
    .raddr0 (idx0),
    .raddr1 (idx1),
    .rdata0 (mem_q0),
    .rdata1 (mem_q1)
  );

  assign mem_read_data0 = (mem_grant0 && mem_read0) ? mem_q0 : '0;
  assign mem_read_data1 = (mem_grant1 && mem_read1) ? mem_q1 : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant  <= LAST_GRANT_RST;
      wait_count0 <= '0;
      wait_count1 <= '0;
    end else begin
      if (mem_grant0) begin
        last_grant <= core_idx_t'(0);
      end else if (mem_grant1) begin
        last_grant <= core_idx_t'(1);
      end
      if (mem_request0 && !mem_grant0) begin
        wait_count0 <= sat_inc(wait_count0);
      end
      if (mem_request1 && !mem_grant1) begin
        wait_count1 <= sat_inc(wait_count1);
      end
    end
  end

endmodule

// File: tb/tb_dual_core_mem_arbiter.sv
// tb/tb_dual_core_mem_arbiter.sv - self-checking bench for dual_core_mem_arbiter
module tb_dual_core_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        r0, r1, rd0, rd1, w0, w1;
  logic [31:0] a0, a1, d0, d1;
  logic        g0, g1;
  logic [31:0] q0, q1;
  logic [15:0] wc0, wc1;
  logic        lg;

  int n_cmp;
  int n_fail;

  dual_core_mem_arbiter #(.ADDR_W(8)) dut (
    .clk             (clk),
    .rst             (rst),
    .mem_request0    (r0),
    .mem_request1    (r1),
    .mem_read0       (rd0),
    .mem_read1       (rd1),
    .mem_write0      (w0),
    .mem_write1      (w1),
    .mem_address0    (a0),
    .mem_address1    (a1),
    .mem_write_data0 (d0),
    .mem_write_data1 (d1),
    .mem_grant0      (g0),
    .mem_grant1      (g1),
    .mem_read_data0  (q0),
    .mem_read_data1  (q1),
    .wait_count0     (wc0),
    .wait_count1     (wc1),
    .last_grant      (lg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic r0, rd0, w0; logic [31:0] a0, d0;
    logic r1, rd1, w1; logic [31:0] a1, d1;
    logic eg0, eg1; logic [31:0] eq0, eq1;
  } vec_t;

  vec_t vecs[10];

  // Reference state: pointer, wait counters and a plain word array.
  logic        m_last;
  int unsigned m_wc[2];
  logic [31:0] m_mem[256];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    r0 = 1'b0; rd0 = 1'b0; w0 = 1'b0; a0 = '0; d0 = '0;
    r1 = 1'b0; rd1 = 1'b0; w1 = 1'b0; a1 = '0; d1 = '0;
  endtask

  task automatic reset_dut();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_last = 1'b1;
    m_wc[0] = 0;
    m_wc[1] = 0;
    for (int i = 0; i < 256; i++) m_mem[i] = '0;
  endtask

  function automatic int widx(input logic [31:0] addr);
    return int'((addr / 4) % 256);
  endfunction

  initial begin
    n_cmp = 0;
    n_fail = 0;
    rst = 1'b0;
    idle_inputs();

    // Reset state and alternating contention.
    reset_dut();
    check("rst_last_grant", {31'b0, lg}, 32'h1);
    check("rst_wc0", {16'b0, wc0}, 32'h0);
    check("rst_wc1", {16'b0, wc1}, 32'h0);
    r0 = 1'b1; r1 = 1'b1; rd0 = 1'b1; rd1 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #2;
      check($sformatf("alt_g0_%0d", i), {31'b0, g0}, (i % 2 == 0) ? 32'h1 : 32'h0);
      check($sformatf("alt_g1_%0d", i), {31'b0, g1}, (i % 2 == 1) ? 32'h1 : 32'h0);
      tick();
    end
    idle_inputs();
    check("alt_wc0", {16'b0, wc0}, 32'd3);
    check("alt_wc1", {16'b0, wc1}, 32'd3);

    // Vector table: store/load handoff, wrap-around, ungated strobes, contention.
    vecs[0] = '{1'b1, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b1, 32'h0, 32'hDEADBEEF};
    vecs[2] = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h404, 32'h1, 1'b0, 1'b1, 32'h0, 32'h0};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 32'h4, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h1, 32'h0};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 32'h20, 32'h55, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 1'b1, 32'h0, 32'h0};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b1, 1'b0, 32'h4, 32'h0, 1'b1, 1'b0, 32'hDEADBEEF, 32'h0};
    vecs[7] = '{1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b1, 1'b0, 32'h4, 32'h0, 1'b0, 1'b1, 32'h0, 32'h1};
    vecs[8] = '{1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0};
    vecs[9] = '{1'b1, 1'b1, 1'b0, 32'h13, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'hDEADBEEF, 32'h0};
    reset_dut();
    for (int i = 0; i < 10; i++) begin
      r0 = vecs[i].r0; rd0 = vecs[i].rd0; w0 = vecs[i].w0; a0 = vecs[i].a0; d0 = vecs[i].d0;
      r1 = vecs[i].r1; rd1 = vecs[i].rd1; w1 = vecs[i].w1; a1 = vecs[i].a1; d1 = vecs[i].d1;
      #2;
      check($sformatf("vec%0d_g0", i), {31'b0, g0}, {31'b0, vecs[i].eg0});
      check($sformatf("vec%0d_g1", i), {31'b0, g1}, {31'b0, vecs[i].eg1});
      check($sformatf("vec%0d_q0", i), q0, vecs[i].eq0);
      check($sformatf("vec%0d_q1", i), q1, vecs[i].eq1);
      tick();
    end
    idle_inputs();

    // Reset during contention with the pointer at core 0.
    reset_dut();
    r0 = 1'b1; w0 = 1'b1; a0 = 32'h10; d0 = 32'hAAAA5555;
    r1 = 1'b1; rd1 = 1'b1; a1 = 32'h14;
    tick();
    check("midrst_last_before", {31'b0, lg}, 32'h0);
    w0 = 1'b0; rd0 = 1'b1;
    rd1 = 1'b0; w1 = 1'b1; d1 = 32'h12345678;
    rst = 1'b1;
    #2;
    check("midrst_g0_in_rst", {31'b0, g0}, 32'h0);
    check("midrst_g1_in_rst", {31'b0, g1}, 32'h0);
    tick();
    rst = 1'b0;
    w1 = 1'b0; rd1 = 1'b1;
    #2;
    check("midrst_last_after", {31'b0, lg}, 32'h1);
    check("midrst_wc0", {16'b0, wc0}, 32'h0);
    check("midrst_wc1", {16'b0, wc1}, 32'h0);
    check("midrst_g0", {31'b0, g0}, 32'h1);
    check("midrst_q0_cleared", q0, 32'h0);
    tick();
    #2;
    check("midrst_g1", {31'b0, g1}, 32'h1);
    check("midrst_q1_discarded", q1, 32'h0);
    tick();
    idle_inputs();

    // Saturation of wait_count1 with core 0 pinned as winner.
    reset_dut();
    force dut.last_grant = 1'b1;
    r0 = 1'b1; r1 = 1'b1;
    repeat (65534) tick();
    check("sat_wc1_fffe", {16'b0, wc1}, 32'hFFFE);
    tick();
    check("sat_wc1_ffff", {16'b0, wc1}, 32'hFFFF);
    repeat (4465) tick();
    check("sat_wc1_hold", {16'b0, wc1}, 32'hFFFF);
    check("sat_wc0", {16'b0, wc0}, 32'h0);
    release dut.last_grant;
    idle_inputs();

    // Randomized traffic against the reference model.
    reset_dut();
    for (int c = 0; c < 400; c++) begin
      logic        eg[2];
      logic [31:0] eq[2];
      logic        req[2], rdv[2], wrv[2];
      logic [31:0] adr[2], dat[2];
      rst = ($urandom_range(0, 39) == 0);
      for (int k = 0; k < 2; k++) begin
        req[k] = ($urandom_range(0, 3) != 0);
        rdv[k] = $urandom_range(0, 1) == 1;
        wrv[k] = $urandom_range(0, 1) == 1;
        adr[k] = $urandom & 32'hF000_003F;
        dat[k] = $urandom;
      end
      r0 = req[0]; rd0 = rdv[0]; w0 = wrv[0]; a0 = adr[0]; d0 = dat[0];
      r1 = req[1]; rd1 = rdv[1]; w1 = wrv[1]; a1 = adr[1]; d1 = dat[1];
      eg[0] = 1'b0; eg[1] = 1'b0;
      if (!rst) begin
        if (req[0] && req[1]) eg[1 - int'(m_last)] = 1'b1;
        else begin eg[0] = req[0]; eg[1] = req[1]; end
      end
      for (int k = 0; k < 2; k++)
        eq[k] = (eg[k] && rdv[k]) ? m_mem[widx(adr[k])] : 32'h0;
      #2;
      check($sformatf("rnd%0d_g0", c), {31'b0, g0}, {31'b0, eg[0]});
      check($sformatf("rnd%0d_g1", c), {31'b0, g1}, {31'b0, eg[1]});
      check($sformatf("rnd%0d_q0", c), q0, eq[0]);
      check($sformatf("rnd%0d_q1", c), q1, eq[1]);
      check($sformatf("rnd%0d_last", c), {31'b0, lg}, {31'b0, m_last});
      check($sformatf("rnd%0d_wc0", c), {16'b0, wc0}, m_wc[0]);
      check($sformatf("rnd%0d_wc1", c), {16'b0, wc1}, m_wc[1]);
      if (rst) begin
        m_last = 1'b1;
        m_wc[0] = 0; m_wc[1] = 0;
        for (int i = 0; i < 256; i++) m_mem[i] = '0;
      end else begin
        for (int k = 0; k < 2; k++) begin
          if (eg[k]) m_last = (k == 1);
          if (req[k] && !eg[k] && m_wc[k] < 65535) m_wc[k] = m_wc[k] + 1;
          if (eg[k] && wrv[k]) m_mem[widx(adr[k])] = dat[k];
        end
      end
      tick();
    end
    rst = 1'b0;
    idle_inputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
